lcd_instruction_transmitter: RTL and testbench
==============================================

// Module: lcd_instruction_transmitter
// PURPOSE
//   Downstream of the LCD configure FSM. Takes one 10-bit LCD word per next_instruction pulse:
//   db[9]=RS, db[8]=RW, db[7:0]=byte. Sends it to the character LCD over the 4-bit bus as
//   upper then lower nibble, with enable-strobe and settle timing, then pulses done for one cycle.
//   Clock is 50 MHz (20 ns); default timing values are in clk cycles.
// PARAMETERS
//   SETUP_CYCLES   2     RS/RW/data stable, lcd_e low, before the E pulse (40 ns)
//   E_HIGH_CYCLES  12    lcd_e high width (240 ns)
//   HOLD_CYCLES    1     data held after lcd_e falls (20 ns)
//   GAP_CYCLES     50    idle time between the upper and lower nibble (1 us)
//   CMD_WAIT       2000  settle time after the lower nibble, before done (40 us)
//   All parameters are 1..4095; one shared 12-bit down-counter.
// PORTS
//   clk               input   1   system clock, 50 MHz
//   reset             input   1   synchronous, active-low reset (0 = reset), sampled on rising clk
//   next_instruction  input   1   1-cycle request from the configure FSM; db valid from the next cycle
//   db                input   10  {RS, RW, D[7:0]} word to send
//   done              output  1   1-cycle pulse: word sent and settle time elapsed
//   busy              output  1   1 in every state except IDLE
//   lcd_e             output  1   LCD enable strobe
//   lcd_rs            output  1   LCD register select
//   lcd_rw            output  1   LCD read/write (driven from db[8])
//   sf_d              output  4   LCD data nibble (DB7..DB4)
// BEHAVIOUR
//   - All outputs are registered.
//   - reset=0 at a clk edge: state=IDLE, counter=0, captured word=0,
//     done=0, busy=0, lcd_e=0, lcd_rs=0, lcd_rw=0, sf_d=0.
//     This applies mid-transfer too: the word is abandoned, lcd_e drops at once, and done is not
//     issued. After reset releases, the first next_instruction starts a fresh transfer.
//   - States: IDLE > LATCH > U_SETUP > U_PULSE > U_HOLD > GAP > L_SETUP > L_PULSE > L_HOLD
//     > WAIT > IDLE.
//   - IDLE: lcd_e=0, sf_d/rs/rw hold their last values. next_instruction=1 > LATCH.
//   - LATCH: exactly 1 cycle. The upstream FSM updates db one cycle after raising
//     next_instruction, so db is captured on the edge that leaves LATCH, not in IDLE.
//   - U_SETUP: sf_d=word[7:4], lcd_rs=word[9], lcd_rw=word[8], lcd_e=0, for SETUP_CYCLES.
//   - U_PULSE: lcd_e=1 for E_HIGH_CYCLES.
//   - U_HOLD: lcd_e=0, data unchanged, for HOLD_CYCLES.
//   - GAP: lcd_e=0 for GAP_CYCLES.
//   - L_SETUP / L_PULSE / L_HOLD: same as the upper nibble but with sf_d=word[3:0].
//   - WAIT: lcd_e=0 for CMD_WAIT.
//   - Last WAIT cycle: next edge sets done=1 and state=IDLE. done is 0 on the following edge,
//     unconditionally.
//   - Latency: with defaults, done is high exactly 2081 cycles after the edge that sampled
//     next_instruction=1 (1+2+12+1+50+2+12+1+2000).
//   - RS/RW stay stable across both nibbles and across every lcd_e edge.
//   - next_instruction while busy=1 (LATCH..WAIT) is ignored and not queued.
//     next_instruction in the same cycle done=1 is accepted, because the state is already IDLE.
//   - Each phase counter loads (N-1) on phase entry and the state advances on count==0.
//     The counter never wraps.
//   - The block does not check long-execution commands such as clear display.
//     Upstream adds the 1.64 ms wait after done.
// TESTING
//   - Reset: hold reset=0 for 3 cycles with next_instruction=1 > all outputs 0, busy=0,
//     done never asserted.
//   - Command 0x028 (function set): pulse next_instruction, db=0x028 the cycle after >
//     sf_d=4'h2 with 12-cycle lcd_e, 50-cycle gap, then sf_d=4'h8 with 12-cycle lcd_e;
//     rs=0, rw=0; done exactly at cycle +2081.
//   - Data 0x243 ('C'): rs=1 through both nibbles, sf_d 4'h4 then 4'h3, single done pulse.
//   - Back-to-back: assert next_instruction the cycle after done, 16 times with line data >
//     16 done pulses, 2082-cycle spacing, nibble order preserved.
//   - next_instruction pulsed during U_PULSE and during WAIT > ignored; exactly one done;
//     captured word unchanged.
//   - reset=0 during L_PULSE > lcd_e=0 on the next edge, no done. A new 0x001 after release
//     is sent correctly.

Source files
------------

// File: rtl/lcd_instruction_transmitter_if.sv
// Handshake and LCD pin bundle between the configure FSM, the instruction
// transmitter and the character LCD 4-bit bus.
interface lcd_instruction_transmitter_if;
    logic       next_instruction;
    logic [9:0] db;
    logic       done;
    logic       busy;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] sf_d;

    // Upstream side: issues words, observes completion and the LCD pins.
    modport master (
        output next_instruction,
        output db,
        input  done,
        input  busy,
        input  lcd_e,
        input  lcd_rs,
        input  lcd_rw,
        input  sf_d
    );

    // Transmitter side.
    modport slave (
        input  next_instruction,
        input  db,
        output done,
        output busy,
        output lcd_e,
        output lcd_rs,
        output lcd_rw,
        output sf_d
    );
endinterface

// File: rtl/lcd_instruction_transmitter.sv
// Sends one 10-bit LCD word {RS, RW, D[7:0]} over the 4-bit character LCD bus
// as upper then lower nibble, with setup / enable / hold / gap / settle timing
// driven by a single shared 12-bit down-counter. Pulses done when finished.
module lcd_instruction_transmitter #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned E_HIGH_CYCLES = 12,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned GAP_CYCLES    = 50,
    parameter int unsigned CMD_WAIT      = 2000
) (
    input  logic                          clk,
    input  logic                          reset,
    lcd_instruction_transmitter_if.slave  bus
);

    // Phase reload values: each phase loads N-1 and advances on zero.
    localparam logic [11:0] LD_SETUP = 12'(SETUP_CYCLES  - 1);
    localparam logic [11:0] LD_E     = 12'(E_HIGH_CYCLES - 1);
    localparam logic [11:0] LD_HOLD  = 12'(HOLD_CYCLES   - 1);
    localparam logic [11:0] LD_GAP   = 12'(GAP_CYCLES    - 1);
    localparam logic [11:0] LD_WAIT  = 12'(CMD_WAIT      - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LATCH   = 4'd1,
        U_SETUP = 4'd2,
        U_PULSE = 4'd3,
        U_HOLD  = 4'd4,
        GAP     = 4'd5,
        L_SETUP = 4'd6,
        L_PULSE = 4'd7,
        L_HOLD  = 4'd8,
        WAIT    = 4'd9
    } state_t;

    state_t      state_r, state_s;
    logic [11:0] cnt_r, cnt_s;
    logic [9:0]  word_r, word_s;
    logic        done_r, done_s;
    logic        busy_r, busy_s;
    logic        lcd_e_r, lcd_e_s;
    logic        lcd_rs_r, lcd_rs_s;
    logic        lcd_rw_r, lcd_rw_s;
    logic [3:0]  sf_d_r, sf_d_s;
    logic        cnt_zero_s;

    assign cnt_zero_s = (cnt_r == 12'd0);

    // Next-state, counter and registered-output values for every phase.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        word_s   = word_r;
        done_s   = 1'b0;
        lcd_rs_s = lcd_rs_r;
        lcd_rw_s = lcd_rw_r;
        sf_d_s   = sf_d_r;

        case (state_r)
            IDLE: begin
                if (bus.next_instruction) begin
                    state_s = LATCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LATCH: begin
                // db becomes valid one cycle after the request, so capture here.
                word_s   = bus.db;
                lcd_rs_s = bus.db[9];
                lcd_rw_s = bus.db[8];
                sf_d_s   = bus.db[7:4];
                cnt_s    = LD_SETUP;
                state_s  = U_SETUP;
            end
            U_SETUP: begin
                if (cnt_zero_s) begin
                    state_s = U_PULSE;
                    cnt_s   = LD_E;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            U_PULSE: begin
                if (cnt_zero_s) begin
                    state_s = U_HOLD;
                    cnt_s   = LD_HOLD;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            U_HOLD: begin
                if (cnt_zero_s) begin
                    state_s = GAP;
                    cnt_s   = LD_GAP;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            GAP: begin
                if (cnt_zero_s) begin
                    state_s = L_SETUP;
                    cnt_s   = LD_SETUP;
                    sf_d_s  = word_r[3:0];
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            L_SETUP: begin
                if (cnt_zero_s) begin
                    state_s = L_PULSE;
                    cnt_s   = LD_E;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            L_PULSE: begin
                if (cnt_zero_s) begin
                    state_s = L_HOLD;
                    cnt_s   = LD_HOLD;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            L_HOLD: begin
                if (cnt_zero_s) begin
                    state_s = WAIT;
                    cnt_s   = LD_WAIT;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            WAIT: begin
                if (cnt_zero_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r - 12'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 12'd0;
            end
        endcase

        // Outputs are registered, so they follow the state being entered.
        busy_s  = (state_s != IDLE);
        lcd_e_s = (state_s == U_PULSE) || (state_s == L_PULSE);
    end

    // State, counter, captured word and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 12'd0;
            word_r   <= 10'd0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            lcd_e_r  <= 1'b0;
            lcd_rs_r <= 1'b0;
            lcd_rw_r <= 1'b0;
            sf_d_r   <= 4'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            word_r   <= word_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            lcd_e_r  <= lcd_e_s;
            lcd_rs_r <= lcd_rs_s;
            lcd_rw_r <= lcd_rw_s;
            sf_d_r   <= sf_d_s;
        end
    end

    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    assign bus.lcd_e  = lcd_e_r;
    assign bus.lcd_rs = lcd_rs_r;
    assign bus.lcd_rw = lcd_rw_r;
    assign bus.sf_d   = sf_d_r;

endmodule

// File: tb/tb_lcd_instruction_transmitter.sv
// Scoreboard bench for lcd_instruction_transmitter: stimulus pushes the word
// and request edge; a negedge monitor records E pulses and checks each done.
module tb_lcd_instruction_transmitter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    lcd_instruction_transmitter_if bus_if ();

    lcd_instruction_transmitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic [9:0] word;
        int         req;
    } exp_t;

    exp_t q[$];

    always #10 clk = ~clk;

    // Rising-edge counter; at a negedge, cyc names the edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    int       npulse = 0;
    bit       prev_e = 1'b0;
    int       rise_c [2];
    bit [3:0] nib    [2];
    bit       rs_v   [2];
    bit       rw_v   [2];

    // Monitor: track E pulses, compare each done against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            npulse = 0;
            prev_e = 1'b0;
        end else begin
            if (bus_if.lcd_e && !prev_e) begin
                if (npulse < 2) begin
                    rise_c[npulse] = cyc;
                    nib[npulse]    = bus_if.sf_d;
                    rs_v[npulse]   = bus_if.lcd_rs;
                    rw_v[npulse]   = bus_if.lcd_rw;
                end
                npulse++;
            end
            if (!bus_if.lcd_e && prev_e && npulse >= 1 && npulse <= 2) begin
                check("e_width", cyc - rise_c[npulse-1], 12);
                check("e_data_stable",
                      {bus_if.lcd_rs, bus_if.lcd_rw, bus_if.sf_d},
                      {rs_v[npulse-1], rw_v[npulse-1], nib[npulse-1]});
            end
            if (bus_if.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pulse_count", npulse, 2);
                    check("upper_nibble", nib[0], e.word[7:4]);
                    check("lower_nibble", nib[1], e.word[3:0]);
                    check("rs_rw_upper", {rs_v[0], rw_v[0]}, e.word[9:8]);
                    check("rs_rw_lower", {rs_v[1], rw_v[1]}, e.word[9:8]);
                    check("upper_rise_time", rise_c[0] - e.req, 3);
                    check("lower_rise_time", rise_c[1] - e.req, 68);
                    check("done_latency", cyc - e.req, 2081);
                    check("busy_at_done", bus_if.busy, 0);
                end
                npulse = 0;
            end
            prev_e = bus_if.lcd_e;
        end
    end

    // Called at a negedge: request now, word on the following cycle.
    task automatic send(input logic [9:0] word, input bit track);
        exp_t e;
        bus_if.next_instruction = 1'b1;
        e.word = word;
        e.req  = cyc + 1;
        if (track) q.push_back(e);
        @(negedge clk);
        bus_if.next_instruction = 1'b0;
        bus_if.db = word;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus_if.done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    int req_c;

    initial begin
        bus_if.next_instruction = 1'b1;
        bus_if.db = 10'h3FF;
        reset = 1'b0;

        // Reset held 3 cycles with next_instruction asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  {bus_if.done, bus_if.busy, bus_if.lcd_e, bus_if.lcd_rs,
                   bus_if.lcd_rw, bus_if.sf_d}, 0);
        end
        reset = 1'b1;
        bus_if.next_instruction = 1'b0;
        wait_cycles(3);
        check("idle_after_reset", {bus_if.busy, bus_if.lcd_e}, 0);

        // Function set 0x028.
        send(10'h028, 1'b1);
        check("busy_during", bus_if.busy, 1);
        wait_done();
        @(negedge clk);
        check("done_one_cycle", bus_if.done, 0);

        // Data 'C' with RS=1.
        wait_cycles(2);
        send(10'h243, 1'b1);
        wait_done();

        // 16 back-to-back words, each requested in the done cycle.
        wait_cycles(2);
        for (int i = 0; i < 16; i++) begin
            send(10'h241 + 10'(i), 1'b1);
            wait_done();
        end

        // Requests during U_PULSE and WAIT are ignored.
        wait_cycles(2);
        req_c = cyc + 1;
        send(10'h0C5, 1'b1);
        while (cyc < req_c + 5) @(negedge clk);
        bus_if.next_instruction = 1'b1;
        bus_if.db = 10'h3FF;
        @(negedge clk);
        bus_if.next_instruction = 1'b0;
        while (cyc < req_c + 500) @(negedge clk);
        bus_if.next_instruction = 1'b1;
        bus_if.db = 10'h13A;
        @(negedge clk);
        bus_if.next_instruction = 1'b0;
        wait_done();
        wait_cycles(2200);
        check("idle_after_ignored", bus_if.busy, 0);

        // Reset during L_PULSE abandons the word.
        req_c = cyc + 1;
        send(10'h2AB, 1'b0);
        while (cyc < req_c + 70) @(negedge clk);
        check("in_lower_pulse", bus_if.lcd_e, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_outputs",
              {bus_if.done, bus_if.busy, bus_if.lcd_e, bus_if.lcd_rs,
               bus_if.lcd_rw, bus_if.sf_d}, 0);
        reset = 1'b1;
        wait_cycles(2100);
        check("no_done_after_abort", bus_if.busy, 0);

        // Fresh transfer after reset release.
        send(10'h001, 1'b1);
        wait_done();
        wait_cycles(5);

        check("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
